stochastic_to_binary_counter: RTL and testbench
===============================================

// Module: stochastic_to_binary_counter
// PURPOSE
//   Decoder end of the stochastic datapath: converts a unipolar stochastic bitstream back to binary.
//   Counts the 1s in a fixed window of valid samples and presents the count as an unsigned binary value.
//   Sits after the stochastic multiplier/adder core and feeds the binary result to the output pins.
//   Window length matches the period of the team's 2^WIDTH-1 LFSR-based encoders.
// PARAMETERS
//   WIDTH   8   result width; window length WINDOW = 2^WIDTH - 1 valid samples
// PORTS
//   clk           in   1      system clock; all logic on rising edge
//   rst           in   1      synchronous reset, active-high
//   start         in   1      request a new conversion window
//   bit_in        in   1      stochastic bitstream sample
//   bit_valid     in   1      bit_in is a valid sample this cycle
//   busy          out  1      high while accumulating (ACCUM state)
//   result        out  WIDTH  count of 1s in the last completed window
//   result_valid  out  1      one-cycle pulse when result updates
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is synchronous and active-high.
//   Reset: state=IDLE; busy=0, result=0, result_valid=0; sample_cnt=0, ones_cnt=0.
//   rst takes priority over every other input, including mid-window; an aborted window never pulses
//     result_valid and leaves result=0.
//   States: IDLE, ACCUM, DONE.
//   IDLE: busy=0. start=1 -> ACCUM next cycle, clear sample_cnt and ones_cnt.
//     bit_in in the start cycle is not counted.
//   ACCUM: busy=1. Each cycle with bit_valid=1: sample_cnt += 1, ones_cnt += bit_in.
//     bit_valid=0 cycles: counters hold, window does not advance, with no timeout.
//     start is ignored in ACCUM.
//     On the accepted sample where sample_cnt == WINDOW-1:
//       - result <= ones_cnt + bit_in;
//       - state -> DONE.
//   DONE: exactly one cycle; result_valid=1, busy=0.
//     start=1 in DONE -> ACCUM next cycle with counters cleared (back-to-back windows).
//     Otherwise -> IDLE.
//   Width rules:
//     - ones_cnt and sample_cnt are WIDTH bits; max count WINDOW = 2^WIDTH-1 fits, so no overflow or wrap.
//     - result is unsigned; result/WINDOW encodes probability p.
//   Latency: with start at cycle 0 and bit_valid continuously high:
//     - samples are taken in cycles 1..WINDOW;
//     - result_valid is high in cycle WINDOW+1.
//   Throughput: back-to-back period with start held = WINDOW+1 cycles.
//   result holds its value from DONE until the next DONE or rst; outputs are registered.
// TESTING
//   1. WIDTH=8, start@0, bit_in=1, bit_valid=1 -> busy 1..255, result_valid only @256, result=255.
//   2. Same, but bit_in=0 throughout -> result_valid @256, result=0.
//   3. bit_in alternating 1,0,... starting with 1 in cycle 1 -> result=128 @256.
//   4. bit_valid high every other cycle, bit_in=1 -> result_valid only after 255 valid samples,
//      result=255; also check that invalid cycles do not count when bit_in=1 on them.
//   5. rst pulsed in cycle 101 of a window -> next cycle busy=0, result=0, no result_valid;
//      a new start then converts normally.
//   6. start held high from cycle 0 with an all-ones stream -> result_valid @256, @512, @768;
//      result=255 each time; start during ACCUM has no effect.

Source files
------------

// File: rtl/stochastic_to_binary_counter.sv
// Stochastic-to-binary decoder: counts the 1s in a window of 2^WIDTH-1 valid
// samples and presents the count as an unsigned result with a one-cycle valid pulse.
module stochastic_to_binary_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    // Index of the final sample in a window (WINDOW-1 = 2^WIDTH-2).
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'((2 ** WIDTH) - 2);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic [WIDTH-1:0] ones_cnt_q, ones_cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        result_d     = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACCUM;
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    ones_cnt_d   = ones_cnt_q + WIDTH'(bit_in);
                    if (sample_cnt_q == LAST_IDX) begin
                        result_d = ones_cnt_q + WIDTH'(bit_in);
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d      = ACCUM;
                    sample_cnt_d = '0;
                    ones_cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state's decode.
        busy_d         = (state_d == ACCUM);
        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sample_cnt_q   <= '0;
            ones_cnt_q     <= '0;
            result_q       <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            ones_cnt_q     <= ones_cnt_d;
            result_q       <= result_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_stochastic_to_binary_counter.sv
// Bench for stochastic_to_binary_counter: directed windows with literal
// expectations plus random stimulus checked every cycle against a queue model.
module tb_stochastic_to_binary_counter;

    localparam int WIDTH  = 8;
    localparam int WINDOW = (2 ** WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    stochastic_to_binary_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a window is just the list of accepted samples; when it holds
    // WINDOW entries the result is their sum.
    localparam int PH_IDLE = 0, PH_ACC = 1, PH_DONE = 2;
    int phase = PH_IDLE;
    bit samples[$];
    int m_result = 0;

    always @(posedge clk) begin
        if (rst) begin
            phase = PH_IDLE;
            samples.delete();
            m_result = 0;
        end else begin
            case (phase)
                PH_IDLE: if (start) begin
                    phase = PH_ACC;
                    samples.delete();
                end
                PH_ACC: begin
                    if (bit_valid) samples.push_back(bit_in);
                    if (samples.size() == WINDOW) begin
                        m_result = 0;
                        foreach (samples[i]) m_result += int'(samples[i]);
                        phase = PH_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        phase = PH_ACC;
                        samples.delete();
                    end else begin
                        phase = PH_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", int'(busy), int'(phase == PH_ACC));
            chk("result_valid", int'(result_valid), int'(phase == PH_DONE));
            chk("result", int'(result), m_result);
        end
    end

    // One window from start at cycle 0. mode: 0 all ones, 1 all zeros,
    // 2 alternating 1,0 from cycle 1, 3 valid on odd cycles only with bit_in=1 always.
    task automatic directed(input int mode, input string nm, input int exp_cycle,
                            input int exp_res, input int exp_busy);
        int rv_cycle = -1;
        int res = -1;
        int busy_cycles = 0;
        @(negedge clk);
        start     = 1'b1;
        bit_in    = (mode == 0 || mode == 3);
        bit_valid = 1'b1;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (result_valid) begin
                rv_cycle = cyc;
                res = int'(result);
                break;
            end
            case (mode)
                0: begin bit_in = 1'b1; bit_valid = 1'b1; end
                1: begin bit_in = 1'b0; bit_valid = 1'b1; end
                2: begin bit_in = cyc[0]; bit_valid = 1'b1; end
                default: begin bit_in = 1'b1; bit_valid = cyc[0]; end
            endcase
        end
        bit_valid = 1'b0;
        chk({nm, "_rv_cycle"}, rv_cycle, exp_cycle);
        chk({nm, "_result"}, res, exp_res);
        chk({nm, "_busy_cycles"}, busy_cycles, exp_busy);
        @(negedge clk);
        chk({nm, "_back_idle"}, int'(busy) + int'(result_valid), 0);
    endtask

    initial begin
        int rv_seen;
        int rv_cycles[$];
        int rv_results[$];
        int bias;

        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_result_valid", int'(result_valid), 0);
        chk("reset_result", int'(result), 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        directed(0, "ones", WINDOW + 1, 255, 255);
        directed(1, "zeros", WINDOW + 1, 0, 255);
        directed(2, "alternate", WINDOW + 1, 128, 255);
        directed(3, "half_valid", 2 * WINDOW, 255, 2 * WINDOW - 1);
        directed(2, "alternate_again", WINDOW + 1, 128, 255);

        // Abort a window at cycle 101; result from the previous window must be cleared.
        @(negedge clk);
        start = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        for (int cyc = 1; cyc <= 101; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_result_valid", int'(result_valid), 0);
        rv_seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (result_valid) rv_seen++;
        end
        chk("abort_no_pulse", rv_seen, 0);
        bit_valid = 1'b0;
        directed(0, "after_abort", WINDOW + 1, 255, 255);

        // start held high: back-to-back windows every WINDOW+1 cycles.
        @(negedge clk);
        start = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        for (int cyc = 1; cyc <= 800; cyc++) begin
            @(negedge clk);
            if (result_valid) begin
                rv_cycles.push_back(cyc);
                rv_results.push_back(int'(result));
            end
        end
        start = 1'b0; bit_valid = 1'b0;
        chk("b2b_count", rv_cycles.size(), 3);
        if (rv_cycles.size() == 3) begin
            chk("b2b_cycle0", rv_cycles[0], 256);
            chk("b2b_cycle1", rv_cycles[1], 512);
            chk("b2b_cycle2", rv_cycles[2], 768);
            foreach (rv_results[i]) chk("b2b_result", rv_results[i], 255);
        end
        repeat (3) @(negedge clk);

        // Random traffic against the model.
        bias = 50;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (cyc % 1000 == 0) bias = int'($urandom_range(0, 100));
            rst       = ($urandom_range(0, 3999) == 0);
            start     = ($urandom_range(0, 9) == 0);
            bit_in    = (int'($urandom_range(0, 99)) < bias);
            bit_valid = ($urandom_range(0, 4) != 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
